// File: rtl/dso_dm_pkg.sv
// Shared DataMover definitions for the DSO capture (S2MM) and readback (MM2S) paths:
// reader FSM states, command/status field positions and error codes.
package dso_dm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_CMD,
    ST_XFER,
    ST_STS,
    ST_ERROR
  } dm_state_e;

  localparam int unsigned DM_CMD_W      = 72;
  localparam int unsigned CMD_BTT_LSB   = 0;
  localparam int unsigned CMD_BTT_W     = 23;
  localparam int unsigned CMD_TYPE_BIT  = 23;
  localparam int unsigned CMD_EOF_BIT   = 30;
  localparam int unsigned CMD_ADDR_LSB  = 32;
  localparam int unsigned CMD_ADDR_W    = 32;
  localparam int unsigned CMD_TAG_LSB   = 64;
  localparam int unsigned CMD_TAG_W     = 4;

  localparam int unsigned STS_TAG_LSB    = 0;
  localparam int unsigned STS_TAG_W      = 4;
  localparam int unsigned STS_INTERR_BIT = 4;
  localparam int unsigned STS_DECERR_BIT = 5;
  localparam int unsigned STS_SLVERR_BIT = 6;
  localparam int unsigned STS_OKAY_BIT   = 7;

  localparam logic [2:0] ERR_NONE = 3'd0;
  localparam logic [2:0] ERR_SLV  = 3'd1;
  localparam logic [2:0] ERR_LEN  = 3'd2;
  localparam logic [2:0] ERR_TAG  = 3'd3;

endpackage

// File: rtl/dm_cmd_pack.sv
// Forms a 72-bit DataMover command word (INCR burst, DSA/DRR/reserved zero).
// Shared by the S2MM writer and the MM2S reader.
module dm_cmd_pack
  import dso_dm_pkg::*;
(
  input  logic [31:0]         addr_i,
  input  logic [22:0]         btt_i,
  input  logic [3:0]          tag_i,
  input  logic                eof_i,
  output logic [DM_CMD_W-1:0] cmd_o
);

  always_comb begin
    cmd_o = '0;
    cmd_o[CMD_BTT_LSB +: CMD_BTT_W]   = btt_i;
    cmd_o[CMD_TYPE_BIT]               = 1'b1;
    cmd_o[CMD_EOF_BIT]                = eof_i;
    cmd_o[CMD_ADDR_LSB +: CMD_ADDR_W] = addr_i;
    cmd_o[CMD_TAG_LSB +: CMD_TAG_W]   = tag_i;
  end

endmodule

// File: rtl/dm_mm2s_reader.sv
// MM2S ring-buffer reader: issues DataMover read commands behind the writer pointer,
// passes data through, checks status. Define DM_READER_TAG_CHECK_EN to verify status tags.
module dm_mm2s_reader
  import dso_dm_pkg::*;
#(
  parameter logic [31:0] BUF_BASE = 32'h0000_0000,
  parameter logic [31:0] BUF_SIZE = 32'h0010_0000,
  parameter int unsigned BTT      = 4096
) (
  input  logic                axi_aclk,
  input  logic                axi_aresetn,
  input  logic                start,
  input  logic                stop,
  input  logic [31:0]         wr_ptr,
  output logic                m_axis_cmd_tvalid,
  input  logic                m_axis_cmd_tready,
  output logic [DM_CMD_W-1:0] m_axis_cmd_tdata,
  input  logic                s_axis_data_tvalid,
  output logic                s_axis_data_tready,
  input  logic [127:0]        s_axis_data_tdata,
  input  logic                s_axis_data_tlast,
  input  logic                s_axis_sts_tvalid,
  output logic                s_axis_sts_tready,
  input  logic [7:0]          s_axis_sts_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic [127:0]        m_axis_tdata,
  output logic                m_axis_tlast,
  output logic [31:0]         rd_ptr,
  output logic                busy,
  output logic                err,
  output logic [2:0]          err_code
);

  localparam logic [31:0]    MASK      = BUF_SIZE - 32'd1;
  localparam int unsigned    NBEATS    = BTT / 16;
  localparam int unsigned    CW        = $clog2(NBEATS + 1);
  localparam logic [CW-1:0]  LAST_BEAT = CW'(NBEATS - 1);
  localparam logic [CW-1:0]  OVER_BEAT = CW'(NBEATS);

  dm_state_e     state_q;
  logic [31:0]   rd_ptr_q, rd_ptr_d, avail;
  logic [3:0]    tag_q;
  logic [CW-1:0] cnt_q;
  logic          stop_q, cmd_valid_q, xfer_q, sts_ready_q, busy_q, err_q;
  logic [2:0]    err_code_q;
  logic          beat, len_bad, sts_bad;
  logic [2:0]    sts_code;

  assign avail    = (wr_ptr - rd_ptr_q) & MASK;
  assign rd_ptr_d = (rd_ptr_q + 32'(BTT)) & MASK;
  assign beat     = xfer_q & s_axis_data_tvalid & m_axis_tready;
  // A beat past the expected count is an error even if it carries tlast.
  assign len_bad  = (cnt_q == OVER_BEAT) | (s_axis_data_tlast & (cnt_q != LAST_BEAT));

  always_comb begin
    sts_bad  = 1'b0;
    sts_code = ERR_NONE;
    if (s_axis_sts_tdata[STS_INTERR_BIT] | s_axis_sts_tdata[STS_DECERR_BIT] |
        s_axis_sts_tdata[STS_SLVERR_BIT] | ~s_axis_sts_tdata[STS_OKAY_BIT]) begin
      sts_bad  = 1'b1;
      sts_code = ERR_SLV;
    end
`ifdef DM_READER_TAG_CHECK_EN
    else if (s_axis_sts_tdata[STS_TAG_LSB +: STS_TAG_W] != tag_q) begin
      sts_bad  = 1'b1;
      sts_code = ERR_TAG;
    end
`endif
  end

`ifndef DM_READER_TAG_CHECK_EN
  logic unused_sts_tag;
  assign unused_sts_tag = ^s_axis_sts_tdata[STS_TAG_LSB +: STS_TAG_W];
`endif

  dm_cmd_pack u_cmd_pack (
    .addr_i (BUF_BASE + rd_ptr_q),
    .btt_i  (23'(BTT)),
    .tag_i  (tag_q),
    .eof_i  (1'b1),
    .cmd_o  (m_axis_cmd_tdata)
  );

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q     <= ST_IDLE;
      rd_ptr_q    <= '0;
      tag_q       <= '0;
      cnt_q       <= '0;
      stop_q      <= 1'b0;
      cmd_valid_q <= 1'b0;
      xfer_q      <= 1'b0;
      sts_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      if (stop && state_q != ST_IDLE) stop_q <= 1'b1;
      unique case (state_q)
        ST_IDLE, ST_ERROR: begin
          if (start) begin
            state_q    <= ST_WAIT;
            rd_ptr_q   <= '0;
            tag_q      <= '0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            stop_q     <= 1'b0;
            busy_q     <= 1'b1;
          end else if (state_q == ST_ERROR && stop) begin
            state_q <= ST_IDLE;
            stop_q  <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (stop_q || stop) begin
            state_q <= ST_IDLE;
            stop_q  <= 1'b0;
            busy_q  <= 1'b0;
          end else if (avail >= 32'(BTT)) begin
            state_q     <= ST_CMD;
            cmd_valid_q <= 1'b1;
          end
        end
        ST_CMD: begin
          if (m_axis_cmd_tready) begin
            state_q     <= ST_XFER;
            cmd_valid_q <= 1'b0;
            xfer_q      <= 1'b1;
            cnt_q       <= '0;
          end
        end
        ST_XFER: begin
          if (beat) begin
            if (len_bad) begin
              state_q    <= ST_ERROR;
              xfer_q     <= 1'b0;
              busy_q     <= 1'b0;
              err_q      <= 1'b1;
              err_code_q <= ERR_LEN;
            end else if (s_axis_data_tlast) begin
              state_q     <= ST_STS;
              xfer_q      <= 1'b0;
              sts_ready_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        ST_STS: begin
          if (s_axis_sts_tvalid) begin
            sts_ready_q <= 1'b0;
            if (sts_bad) begin
              state_q    <= ST_ERROR;
              busy_q     <= 1'b0;
              err_q      <= 1'b1;
              err_code_q <= sts_code;
            end else begin
              state_q  <= ST_WAIT;
              rd_ptr_q <= rd_ptr_d;
              tag_q    <= tag_q + 4'd1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign m_axis_cmd_tvalid  = cmd_valid_q;
  assign s_axis_data_tready = xfer_q & m_axis_tready;
  assign m_axis_tvalid      = xfer_q & s_axis_data_tvalid;
  assign m_axis_tdata       = s_axis_data_tdata;
  assign m_axis_tlast       = xfer_q & s_axis_data_tlast;
  assign s_axis_sts_tready  = sts_ready_q;
  assign rd_ptr             = rd_ptr_q;
  assign busy               = busy_q;
  assign err                = err_q;
  assign err_code           = err_code_q;

endmodule

// File: tb/tb_dm_mm2s_reader.sv
// Directed bench for dm_mm2s_reader with a 4 KiB ring and 1 KiB commands.
module tb_dm_mm2s_reader;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, stop;
  logic [31:0]  wr_ptr;
  logic         cmd_tvalid, cmd_tready;
  logic [71:0]  cmd_tdata;
  logic         d_tvalid, d_tready, d_tlast;
  logic [127:0] d_tdata;
  logic         sts_tvalid, sts_tready;
  logic [7:0]   sts_tdata;
  logic         o_tvalid, o_tready, o_tlast;
  logic [127:0] o_tdata;
  logic [31:0]  rd_ptr;
  logic         busy, err;
  logic [2:0]   err_code;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dm_mm2s_reader #(
    .BUF_BASE (32'h8000_0000),
    .BUF_SIZE (32'd4096),
    .BTT      (1024)
  ) dut (
    .axi_aclk           (clk),
    .axi_aresetn        (rst_n),
    .start              (start),
    .stop               (stop),
    .wr_ptr             (wr_ptr),
    .m_axis_cmd_tvalid  (cmd_tvalid),
    .m_axis_cmd_tready  (cmd_tready),
    .m_axis_cmd_tdata   (cmd_tdata),
    .s_axis_data_tvalid (d_tvalid),
    .s_axis_data_tready (d_tready),
    .s_axis_data_tdata  (d_tdata),
    .s_axis_data_tlast  (d_tlast),
    .s_axis_sts_tvalid  (sts_tvalid),
    .s_axis_sts_tready  (sts_tready),
    .s_axis_sts_tdata   (sts_tdata),
    .m_axis_tvalid      (o_tvalid),
    .m_axis_tready      (o_tready),
    .m_axis_tdata       (o_tdata),
    .m_axis_tlast       (o_tlast),
    .rd_ptr             (rd_ptr),
    .busy               (busy),
    .err                (err),
    .err_code           (err_code)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pat(input int i);
    logic [31:0] w;
    w = 32'hC0DE_0000 ^ 32'(i);
    return {w, ~w, w + 32'd7, 32'(i)};
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic expect_cmd(input logic [31:0] off, input logic [3:0] tag);
    logic [71:0] exp;
    int guard = 0;
    exp          = '0;
    exp[22:0]    = 23'd1024;
    exp[23]      = 1'b1;
    exp[30]      = 1'b1;
    exp[63:32]   = 32'h8000_0000 + off;
    exp[67:64]   = tag;
    #1;
    while (!cmd_tvalid && guard < 50) begin
      @(negedge clk); #1;
      guard++;
    end
    chk("cmd_valid", cmd_tvalid, 1'b1);
    chk("cmd_data", cmd_tdata, exp);
    cmd_tready = 1'b1;
    @(negedge clk);
    cmd_tready = 1'b0;
  endtask

  task automatic send_data(input int n, input int last_idx, input bit bp, input int stop_idx);
    for (int i = 0; i < n; i++) begin
      bit done = 1'b0;
      int guard = 0;
      d_tvalid = 1'b1;
      d_tdata  = pat(i);
      d_tlast  = (i == last_idx);
      stop     = (i == stop_idx);
      while (!done) begin
        o_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        chk("out_valid", o_tvalid, 1'b1);
        chk("rdy_mirror", d_tready, o_tready);
        chk("out_data", o_tdata, pat(i));
        chk("out_last", o_tlast, (i == last_idx));
        done = o_tready;
        @(negedge clk);
        stop = 1'b0;
        guard++;
        if (!done && guard > 200) begin
          chk("bp_timeout", 1'b0, 1'b1);
          done = 1'b1;
        end
      end
    end
    d_tvalid = 1'b0;
    d_tlast  = 1'b0;
    o_tready = 1'b0;
  endtask

  task automatic send_sts(input logic [7:0] d);
    int guard = 0;
    sts_tvalid = 1'b1;
    sts_tdata  = d;
    #1;
    while (!sts_tready && guard < 50) begin
      @(negedge clk); #1;
      guard++;
    end
    chk("sts_ready", sts_tready, 1'b1);
    @(negedge clk);
    sts_tvalid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; wr_ptr = '0;
    cmd_tready = 1'b0; d_tvalid = 1'b0; d_tdata = '0; d_tlast = 1'b0;
    sts_tvalid = 1'b0; sts_tdata = '0; o_tready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_code", err_code, 3'd0);
    chk("rst_rdptr", rd_ptr, 32'd0);
    chk("rst_cmdv", cmd_tvalid, 1'b0);
    chk("rst_stsr", sts_tready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Empty ring: busy but no command.
    pulse_start();
    repeat (4) @(negedge clk);
    chk("empty_busy", busy, 1'b1);
    chk("empty_nocmd", cmd_tvalid, 1'b0);

    // First block: valid one cycle after avail reaches BTT.
    wr_ptr = 32'd1024;
    @(negedge clk); #1;
    chk("cmd_latency", cmd_tvalid, 1'b1);
    expect_cmd(32'd0, 4'd0);
    send_data(64, 63, 1'b0, -1);
    send_sts(8'h80);
    chk("rdptr_1", rd_ptr, 32'd1024);
    chk("err_ok", err, 1'b0);
    pulse_start();
    chk("start_ignored", rd_ptr, 32'd1024);

    // Remaining blocks up to the wrap, one under backpressure.
    wr_ptr = 32'd2048;
    expect_cmd(32'd1024, 4'd1);
    send_data(64, 63, 1'b0, -1);
    send_sts(8'h81);
    wr_ptr = 32'd3072;
    expect_cmd(32'd2048, 4'd2);
    send_data(64, 63, 1'b1, -1);
    send_sts(8'h82);
    wr_ptr = 32'd0;
    expect_cmd(32'd3072, 4'd3);
    send_data(64, 63, 1'b0, -1);
    send_sts(8'h83);
    chk("rdptr_wrap", rd_ptr, 32'd0);
    repeat (3) @(negedge clk);
    chk("wrap_idle_cmd", cmd_tvalid, 1'b0);

    // Early tlast on beat 10.
    wr_ptr = 32'd1024;
    expect_cmd(32'd0, 4'd4);
    send_data(10, 9, 1'b0, -1);
    d_tvalid = 1'b1; o_tready = 1'b1; sts_tvalid = 1'b1;
    #1;
    chk("len_err", err, 1'b1);
    chk("len_code", err_code, 3'd2);
    chk("len_busy", busy, 1'b0);
    chk("len_dready", d_tready, 1'b0);
    chk("len_ovalid", o_tvalid, 1'b0);
    chk("len_stsready", sts_tready, 1'b0);
    d_tvalid = 1'b0; o_tready = 1'b0; sts_tvalid = 1'b0;
    @(negedge clk);

    // Restart clears error; then SLVERR status.
    pulse_start();
    chk("restart_err", err, 1'b0);
    chk("restart_code", err_code, 3'd0);
    chk("restart_rdptr", rd_ptr, 32'd0);
    chk("restart_busy", busy, 1'b1);
    expect_cmd(32'd0, 4'd0);
    send_data(64, 63, 1'b0, -1);
    send_sts(8'h40);
    chk("slv_err", err, 1'b1);
    chk("slv_code", err_code, 3'd1);
    chk("slv_busy", busy, 1'b0);

    // OKAY with a tag that does not match the issued tag 0.
    pulse_start();
    expect_cmd(32'd0, 4'd0);
    send_data(64, 63, 1'b0, -1);
    send_sts(8'h85);
`ifdef DM_READER_TAG_CHECK_EN
    chk("tag_err", err, 1'b1);
    chk("tag_code", err_code, 3'd3);
`else
    chk("tag_ignored_err", err, 1'b0);
    chk("tag_ignored_rdptr", rd_ptr, 32'd1024);
`endif

    // Stop from ERROR or WAIT goes to IDLE.
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    @(negedge clk);
    chk("stop_idle_busy", busy, 1'b0);
`ifdef DM_READER_TAG_CHECK_EN
    chk("stop_err_kept", err, 1'b1);
`endif

    // Stop during a transfer: block completes, then IDLE.
    wr_ptr = 32'd2048;
    pulse_start();
    expect_cmd(32'd0, 4'd0);
    send_data(64, 63, 1'b0, 19);
    send_sts(8'h80);
    chk("stop_rdptr", rd_ptr, 32'd1024);
    @(negedge clk);
    chk("stop_busy", busy, 1'b0);
    chk("stop_nocmd", cmd_tvalid, 1'b0);

    // Asynchronous reset mid-transfer.
    pulse_start();
    expect_cmd(32'd0, 4'd0);
    send_data(5, -1, 1'b0, -1);
    d_tvalid = 1'b1; o_tready = 1'b1;
    #1;
    chk("mid_xfer_valid", o_tvalid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ovalid", o_tvalid, 1'b0);
    chk("arst_dready", d_tready, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_rdptr", rd_ptr, 32'd0);
    chk("arst_cmdv", cmd_tvalid, 1'b0);
    chk("arst_stsr", sts_tready, 1'b0);
    chk("arst_code", err_code, 3'd0);
    d_tvalid = 1'b0; o_tready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dm_mm2s_reader.md
# dm_mm2s_reader

Read-side counterpart of the ADC capture path. Issues AXI DataMover MM2S commands to read captured 128-bit ADC words back out of the DDR3 ring buffer that the S2MM capture writer fills. Forwards the returned stream to a downstream AXI-Stream consumer and tracks a read pointer against the writer's byte pointer. Checks every DataMover status word. Sits in the `axi_aclk` domain beside `adc_to_datamover` in `dso_top`.

## Interface
Parameters:
- `BUF_BASE`, 32'h0000_0000: DDR byte address of ring start.
- `BUF_SIZE`, 32'h0010_0000: ring size in bytes. Must be a power of two.
- `BTT`, 4096: bytes per MM2S command. Must be a multiple of 16, and BUF_SIZE must be an integer multiple of BTT.

Ports:
- `axi_aclk`  in  1: sole clock.
- `axi_aresetn`  in  1: asynchronous, active-low reset.
- `start`  in  1: one-cycle pulse; leave IDLE or ERROR and begin reading at offset 0.
- `stop`  in  1: one-cycle pulse; finish the in-flight command, then go to IDLE.
- `wr_ptr`  in  32: writer byte offset in [0, BUF_SIZE), same clock domain.
- `m_axis_cmd_tvalid` / `m_axis_cmd_tready` / `m_axis_cmd_tdata[71:0]`: MM2S command.
- `s_axis_data_tvalid` / `s_axis_data_tready` / `s_axis_data_tdata[127:0]` / `s_axis_data_tlast`: MM2S data in.
- `s_axis_sts_tvalid` / `s_axis_sts_tready` / `s_axis_sts_tdata[7:0]`: MM2S status.
- `m_axis_tvalid` / `m_axis_tready` / `m_axis_tdata[127:0]` / `m_axis_tlast`: data out.
- `rd_ptr`  out  32: read byte offset.
- `busy`  out  1: high when not in IDLE or ERROR.
- `err`  out  1: sticky error flag.
- `err_code`  out  3: 1 = slave/decode/internal error, 2 = length error, 3 = tag error.

## Operation
- State machine: IDLE, WAIT, CMD, XFER, STS, ERROR.
- IDLE: on `start`, clear `rd_ptr`, tag and `err`; go to WAIT. `start` in ERROR does the same.
- WAIT: `avail = (wr_ptr - rd_ptr) & (BUF_SIZE-1)`.
  - If `stop` is pending, go to IDLE.
  - Else if `avail >= BTT`, go to CMD.
  - `avail == 0` means empty. The writer must never lap the reader, so "full" is not distinguishable and is not handled.
- CMD: drive `m_axis_cmd_tdata` fields as follows.
  - [22:0] = BTT
  - [23] = 1 (INCR)
  - [29:24] = 0
  - [30] = 1 (EOF)
  - [31] = 0
  - [63:32] = BUF_BASE + rd_ptr
  - [67:64] = tag
  - [71:68] = 0
  - On handshake, go to XFER.
- XFER: pass data through combinationally.
  - `m_axis_tvalid = s_axis_data_tvalid`, `s_axis_data_tready = m_axis_tready`, tdata and tlast unchanged.
  - A beat counter counts handshakes against BTT/16.
  - tlast on the final beat: go to STS.
  - tlast early, or a beat beyond BTT/16 without tlast: ERROR with code 2.
- STS: `s_axis_sts_tready` = 1.
  - On handshake, if any of bits [6:4] is set or bit [7] is clear: ERROR with code 1.
  - Otherwise `rd_ptr <= (rd_ptr + BTT) & (BUF_SIZE-1)`, tag increments mod 16, go to WAIT.
- `stop` is latched in any non-IDLE state and acted on only in WAIT. An in-flight command always completes, because DataMover commands cannot be aborted.
- ERROR: `err` = 1. All handshake readies and valids are 0. Exit only on `start`. `stop` in ERROR moves to IDLE with `err` retained.
- `start` while busy is ignored.

## Timing
- Reset values:
  - state IDLE
  - `rd_ptr` = 0, tag = 0
  - `err` = 0, `err_code` = 0, `busy` = 0
  - all tvalid/tready outputs 0
- `m_axis_cmd_tvalid` rises the cycle after WAIT sees `avail >= BTT`. It and tdata are held stable until tready.
- Data path has zero latency and no buffering. `m_axis_*` are only valid in XFER.
- `rd_ptr` updates the cycle after the status handshake. Write-to-next-command turnaround is at least 2 cycles.
- Status arriving before the final data beat is held off, since tready = 0 outside STS.
- Asynchronous reset mid-transfer returns to IDLE immediately. The DataMover must be reset alongside, via a shared `axi_aresetn`.

## Configuration
- `DM_READER_TAG_CHECK_EN` defined: the status tag [3:0] must equal the issued tag; a mismatch goes to ERROR with code 3.
- Not defined: the tag is still issued and incremented, but status bits [3:0] are ignored and code 3 never occurs.

## Structure
- Shared package `dso_dm_pkg`:
  - FSM state enum
  - command field positions and `DM_CMD_W = 72`
  - status bit positions
  - `ERR_SLV`, `ERR_LEN`, `ERR_TAG` code constants
- The S2MM writer uses the same command-field constants.
- One sub-module: `dm_cmd_pack`. A pure function or module forming the 72-bit command from address, BTT, tag and EOF, shared with the writer.

## Test plan
- BUF_SIZE=4096, BTT=1024, wr_ptr=0, start: stays in WAIT, no command issued. Set wr_ptr=1024: one command issued with addr=BUF_BASE, BTT=1024, tag=0; 64 beats pass through with tlast on beat 64; OKAY status (8'h80) advances rd_ptr to 1024.
- wr_ptr steps to 0 after four commands (wrap): 4 commands issued at offsets 0, 1024, 2048, 3072 with tags 0–3; rd_ptr ends at 0.
- Random `m_axis_tready` backpressure (50%): every beat delivered in order with no drops, and `s_axis_data_tready` mirrors `m_axis_tready`.
- tlast on beat 10 of 64: err=1, err_code=2, readies drop. A subsequent start clears err and sets rd_ptr=0.
- Status 8'h40 (SLVERR): err_code=1. With `DM_READER_TAG_CHECK_EN`, status 8'h85 after tag 0: err_code=3; without the macro the same status gives normal advance.
- `stop` pulsed on beat 20 of an XFER: transfer and status complete, rd_ptr advances, then IDLE with busy=0. Reset asserted mid-XFER: all outputs return to reset values within the same cycle.
